// File: rtl/cl_frame_rx.sv
// Camera Link receiver front end: registers the port pins twice, packs the ten taps
// into one 80-bit word, tags SOF/EOL/EOF and checks frame geometry against N_COL x N_ROW.
module cl_frame_rx #(
    parameter int N_COL   = 20,
    parameter int N_ROW   = 4,
    parameter int COL_W   = 10,
    parameter int ROW_W   = 11,
    parameter int FRAME_W = 20
) (
    input  logic               cl_z_pclk,
    input  logic               reset_n,
    input  logic               cl_fval,
    input  logic               cl_z_lval,
    input  logic [7:0]         cl_port_a,
    input  logic [7:0]         cl_port_b,
    input  logic [7:0]         cl_port_c,
    input  logic [7:0]         cl_port_d,
    input  logic [7:0]         cl_port_e,
    input  logic [7:0]         cl_port_f,
    input  logic [7:0]         cl_port_g,
    input  logic [7:0]         cl_port_h,
    input  logic [7:0]         cl_port_i,
    input  logic [7:0]         cl_port_j,
    input  logic               capture_en,
    input  logic               err_clr,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [79:0]        out_data,
    output logic               out_sof,
    output logic               out_eol,
    output logic               out_eof,
    output logic [FRAME_W-1:0] frame_cnt,
    output logic               err_col,
    output logic               err_row,
    output logic               err_lval,
    output logic               err_ovf
);

    typedef enum logic [1:0] {IDLE, ARMED, FRAME} state_t;

    state_t state_reg, state_next;

    logic [7:0]  tap [10];
    logic [79:0] pin_data;

    assign tap[0] = cl_port_a;
    assign tap[1] = cl_port_b;
    assign tap[2] = cl_port_c;
    assign tap[3] = cl_port_d;
    assign tap[4] = cl_port_e;
    assign tap[5] = cl_port_f;
    assign tap[6] = cl_port_g;
    assign tap[7] = cl_port_h;
    assign tap[8] = cl_port_i;
    assign tap[9] = cl_port_j;

    generate
        for (genvar gi = 0; gi < 10; gi++) begin : g_pack
            assign pin_data[gi*8 +: 8] = tap[gi];
        end
    endgenerate

    logic             s1_fval_reg, s1_lval_reg, s2_fval_reg, s2_lval_reg;
    logic [79:0]      s1_data_reg, s2_data_reg;
    logic [COL_W-1:0] col_reg;
    logic [ROW_W-1:0] row_reg;
    logic             sof_pending_reg;

    // s2 is the older sample, so a falling edge shows up as s2=1, s1=0.
    logic eol_d, eof_d, fval_rise, fval_fall, in_frame, word_due, emit, frame_end;
    logic col_bad, row_bad, lval_bad, ovf_bad;

    assign eol_d     = s2_lval_reg & ~s1_lval_reg;
    assign eof_d     = eol_d & s2_fval_reg & ~s1_fval_reg;
    assign fval_rise = s1_fval_reg & ~s2_fval_reg;
    assign fval_fall = s2_fval_reg & ~s1_fval_reg;
    assign in_frame  = (state_reg == FRAME);
    assign word_due  = in_frame & s2_lval_reg & s2_fval_reg;
    assign emit      = word_due & out_ready;
    assign frame_end = in_frame & fval_fall;

    assign col_bad  = word_due & eol_d & ((col_reg + COL_W'(1)) != COL_W'(N_COL));
    assign row_bad  = frame_end & (~eof_d | ((row_reg + ROW_W'(1)) != ROW_W'(N_ROW)));
    assign lval_bad = s2_lval_reg & ~s2_fval_reg;
    assign ovf_bad  = word_due & ~out_ready;

    always_ff @(posedge cl_z_pclk) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // A frame already in progress when armed is skipped: arming needs fval low first.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (capture_en && !s1_fval_reg) state_next = ARMED;
            ARMED:   if (fval_rise) state_next = FRAME;
            FRAME:   if (frame_end) state_next = capture_en ? ARMED : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge cl_z_pclk) begin
        if (!reset_n) begin
            s1_fval_reg     <= 1'b0;
            s1_lval_reg     <= 1'b0;
            s1_data_reg     <= '0;
            s2_fval_reg     <= 1'b0;
            s2_lval_reg     <= 1'b0;
            s2_data_reg     <= '0;
            col_reg         <= '0;
            row_reg         <= '0;
            sof_pending_reg <= 1'b0;
            out_valid       <= 1'b0;
            out_data        <= '0;
            out_sof         <= 1'b0;
            out_eol         <= 1'b0;
            out_eof         <= 1'b0;
            frame_cnt       <= '0;
            err_col         <= 1'b0;
            err_row         <= 1'b0;
            err_lval        <= 1'b0;
            err_ovf         <= 1'b0;
        end else begin
            s1_fval_reg <= cl_fval;
            s1_lval_reg <= cl_z_lval;
            s1_data_reg <= pin_data;
            s2_fval_reg <= s1_fval_reg;
            s2_lval_reg <= s1_lval_reg;
            s2_data_reg <= s1_data_reg;

            // Dropped words lose their tags but still advance the geometry counters.
            out_valid <= emit;
            out_sof   <= emit & sof_pending_reg;
            out_eol   <= emit & eol_d;
            out_eof   <= emit & eof_d;
            if (emit) out_data <= s2_data_reg;

            if (state_reg == ARMED && fval_rise) begin
                sof_pending_reg <= 1'b1;
                col_reg         <= '0;
                row_reg         <= '0;
            end else if (word_due) begin
                sof_pending_reg <= 1'b0;
                if (eol_d) begin
                    col_reg <= '0;
                    if (row_reg != '1) row_reg <= row_reg + ROW_W'(1);
                end else if (col_reg != '1) begin
                    col_reg <= col_reg + COL_W'(1);
                end
            end

            if (frame_end) frame_cnt <= frame_cnt + FRAME_W'(1);

            // A new error in the same cycle as err_clr keeps its flag set.
            err_col  <= (err_col  & ~err_clr) | col_bad;
            err_row  <= (err_row  & ~err_clr) | row_bad;
            err_lval <= (err_lval & ~err_clr) | lval_bad;
            err_ovf  <= (err_ovf  & ~err_clr) | ovf_bad;
        end
    end

endmodule
